// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the integer register file: round-robin arbitration of
// EXU/LSU writebacks onto a registered write port, plus a busy-register scoreboard.
module rf_wb_scheduler #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   input  logic                  iss_wen,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] iss_rs1,
   input  logic [ADDR_WIDTH-1:0] iss_rs2,
   output logic                  iss_hazard,
   input  logic                  wb0_valid,
   input  logic [ADDR_WIDTH-1:0] wb0_rd,
   input  logic [DATA_WIDTH-1:0] wb0_data,
   output logic                  wb0_ready,
   input  logic                  wb1_valid,
   input  logic [ADDR_WIDTH-1:0] wb1_rd,
   input  logic [DATA_WIDTH-1:0] wb1_data,
   output logic                  wb1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [ADDR_WIDTH:0]   pending_cnt,
   output logic                  wb_err
);

   localparam int NumRegs = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CntOne = 1;

   logic [NumRegs-1:0]    busy;
   logic [NumRegs-1:0]    busyNext;
   logic                  lastGrant;
   logic                  grant0;
   logic                  grant1;
   logic                  accValid;
   logic [ADDR_WIDTH-1:0] accRd;
   logic [DATA_WIDTH-1:0] accData;
   logic                  setEn;
   logic                  clrEn;

   // Grants are suppressed while in reset so requesters held valid see no ready.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (wb0_valid && (!wb1_valid || lastGrant)) grant0 = 1'b1;
         else if (wb1_valid)                          grant1 = 1'b1;
      end
   end

   assign wb0_ready = grant0;
   assign wb1_ready = grant1;

   always_comb begin
      accValid = grant0 | grant1;
      accRd    = grant0 ? wb0_rd   : wb1_rd;
      accData  = grant0 ? wb0_data : wb1_data;
   end

   always_comb begin
      iss_hazard = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd]));
      setEn      = iss_valid & ~iss_hazard & iss_wen & (iss_rd != '0);
      // Only a bit that is actually busy counts as a clear, so stray writebacks
      // to idle registers cannot underflow the pending count.
      clrEn      = rf_wen & busy[rf_waddr];
   end

   always_comb begin
      busyNext = busy;
      if (clrEn) busyNext[rf_waddr] = 1'b0;
      if (setEn) busyNext[iss_rd]   = 1'b1;
      busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= '0;
         pending_cnt <= '0;
         rf_wen      <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         wb_err      <= 1'b0;
         lastGrant   <= 1'b1;
      end else begin
         busy <= busyNext;
         case ({setEn, clrEn})
            2'b10:   pending_cnt <= pending_cnt + CntOne;
            2'b01:   pending_cnt <= pending_cnt - CntOne;
            default: pending_cnt <= pending_cnt;
         endcase
         rf_wen <= accValid && (accRd != '0);
         if (accValid) begin
            rf_waddr <= accRd;
            rf_wdata <= accData;
         end
         if (accValid && (accRd != '0) && !busy[accRd]) wb_err <= 1'b1;
         if (grant0)      lastGrant <= 1'b0;
         else if (grant1) lastGrant <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: expected register-file writes are queued
// when a grant is expected and popped whenever the DUT drives rf_wen.
module tb_rf_wb_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iss_valid, iss_wen;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic        iss_hazard;
   logic        wb0_valid, wb1_valid;
   logic [4:0]  wb0_rd, wb1_rd;
   logic [31:0] wb0_data, wb1_data;
   logic        wb0_ready, wb1_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [5:0]  pending_cnt;
   logic        wb_err;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t expQ[$];
   wr_t monExp;
   int  checks = 0;
   int  failures = 0;

   rf_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_hazard(iss_hazard),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pending_cnt(pending_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Scoreboard consumer: every write reaching the register file must match the queue head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rf_wen !== 1'b0) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected rf_wen=%b waddr=%0d wdata=%h, required no write", rf_wen, rf_waddr, rf_wdata);
         end else begin
            monExp = expQ.pop_front();
            if (rf_wen !== 1'b1 || rf_waddr !== monExp.addr || rf_wdata !== monExp.data) begin
               failures++;
               $display("FAIL wb_write got addr=%0d data=%h, required addr=%0d data=%h",
                        rf_waddr, rf_wdata, monExp.addr, monExp.data);
            end
         end
      end
   end

   task automatic idle();
      iss_valid = 1'b0; iss_wen = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
      wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
      wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      expQ.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [4:0] rd);
      @(negedge clk);
      idle();
      iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd6;
      wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h1;
      wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h2;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (rf_wen !== 1'b0 || pending_cnt !== 6'd0 || wb_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got wen=%b pend=%0d err=%b, required 0 0 0", rf_wen, pending_cnt, wb_err);
      end
      checks++;
      if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got r0=%b r1=%b, required 0 0", wb0_ready, wb1_ready);
      end
      checks++;
      if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_wport got addr=%0d data=%h, required 0 0", rf_waddr, rf_wdata);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (rf_wen !== 1'b0 || pending_cnt !== 6'd0 || wb_err !== 1'b0 || iss_hazard !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got wen=%b pend=%0d err=%b haz=%b, required 0 0 0 0",
                  rf_wen, pending_cnt, wb_err, iss_hazard);
      end
   endtask

   task automatic test_raw();
      do_reset();
      issue(5'd5);
      #1;
      checks++;
      if (iss_hazard !== 1'b0) begin
         failures++; $display("FAIL raw_first_issue hazard=%b, required 0", iss_hazard);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (pending_cnt !== 6'd1) begin
         failures++; $display("FAIL raw_pending_set got %0d, required 1", pending_cnt);
      end
      @(negedge clk);
      iss_valid = 1'b1; iss_rs1 = 5'd5;
      #1;
      checks++;
      if (iss_hazard !== 1'b1) begin
         failures++; $display("FAIL raw_hazard got %b, required 1", iss_hazard);
      end
      @(negedge clk);
      wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (wb0_ready !== 1'b1) begin
         failures++; $display("FAIL raw_wb0_ready got %b, required 1", wb0_ready);
      end
      expQ.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
      @(negedge clk);
      wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
      #1;
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL raw_wport got wen=%b addr=%0d data=%h, required 1 5 deadbeef", rf_wen, rf_waddr, rf_wdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (iss_hazard !== 1'b0 || pending_cnt !== 6'd0 || rf_wen !== 1'b0) begin
         failures++;
         $display("FAIL raw_clear got haz=%b pend=%0d wen=%b, required 0 0 0", iss_hazard, pending_cnt, rf_wen);
      end
      idle();
   endtask

   task automatic test_round_robin();
      do_reset();
      issue(5'd3);
      issue(5'd4);
      @(negedge clk);
      idle();
      wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h1111_0003;
      wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h2222_0004;
      #1;
      checks++;
      if (pending_cnt !== 6'd2) begin
         failures++; $display("FAIL rr_pending got %0d, required 2", pending_cnt);
      end
      checks++;
      if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
         failures++; $display("FAIL rr_first_grant got r0=%b r1=%b, required 1 0", wb0_ready, wb1_ready);
      end
      expQ.push_back('{addr: 5'd3, data: 32'h1111_0003});
      @(negedge clk);
      wb0_valid = 1'b0;
      #1;
      checks++;
      if (wb0_ready !== 1'b0 || wb1_ready !== 1'b1) begin
         failures++; $display("FAIL rr_second_grant got r0=%b r1=%b, required 0 1", wb0_ready, wb1_ready);
      end
      expQ.push_back('{addr: 5'd4, data: 32'h2222_0004});
      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0 || pending_cnt !== 6'd0) begin
         failures++; $display("FAIL rr_drain got queued=%0d pend=%0d, required 0 0", expQ.size(), pending_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] p0 [2];
      logic [4:0] p1 [2];
      int         gseq [4];
      int unsigned i0, i1;
      p0[0] = 5'd10; p0[1] = 5'd12;
      p1[0] = 5'd11; p1[1] = 5'd13;
      gseq[0] = 0; gseq[1] = 1; gseq[2] = 0; gseq[3] = 1;
      i0 = 0; i1 = 0;
      do_reset();
      issue(5'd10); issue(5'd11); issue(5'd12); issue(5'd13);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle();
         wb0_valid = (i0 < 2); wb0_rd = p0[i0 < 2 ? i0 : 0]; wb0_data = {27'h5000000, wb0_rd};
         wb1_valid = (i1 < 2); wb1_rd = p1[i1 < 2 ? i1 : 0]; wb1_data = {27'h6000000, wb1_rd};
         #1;
         if (c == 0) begin
            checks++;
            if (pending_cnt !== 6'd4) begin
               failures++; $display("FAIL b2b_pending got %0d, required 4", pending_cnt);
            end
         end
         checks++;
         if (wb0_ready !== (gseq[c] == 0) || wb1_ready !== (gseq[c] == 1)) begin
            failures++;
            $display("FAIL b2b_grant cycle=%0d got r0=%b r1=%b, required port %0d", c, wb0_ready, wb1_ready, gseq[c]);
         end
         if (gseq[c] == 0) begin
            expQ.push_back('{addr: wb0_rd, data: wb0_data});
            i0++;
         end else begin
            expQ.push_back('{addr: wb1_rd, data: wb1_data});
            i1++;
         end
      end
      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0 || pending_cnt !== 6'd0) begin
         failures++; $display("FAIL b2b_drain got queued=%0d pend=%0d, required 0 0", expQ.size(), pending_cnt);
      end
   endtask

   task automatic test_x0();
      do_reset();
      issue(5'd0);
      @(negedge clk);
      idle();
      wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h5555_AAAA;
      #1;
      checks++;
      if (pending_cnt !== 6'd0) begin
         failures++; $display("FAIL x0_pending got %0d, required 0", pending_cnt);
      end
      checks++;
      if (wb1_ready !== 1'b1) begin
         failures++; $display("FAIL x0_ready got %b, required 1", wb1_ready);
      end
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (rf_wen !== 1'b0 || wb_err !== 1'b0) begin
         failures++; $display("FAIL x0_write got wen=%b err=%b, required 0 0", rf_wen, wb_err);
      end
   endtask

   task automatic test_error_waw();
      do_reset();
      @(negedge clk);
      wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h0000_0077;
      #1;
      checks++;
      if (wb0_ready !== 1'b1) begin
         failures++; $display("FAIL err_ready got %b, required 1", wb0_ready);
      end
      expQ.push_back('{addr: 5'd7, data: 32'h0000_0077});
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (wb_err !== 1'b1) begin
         failures++; $display("FAIL err_set got %b, required 1", wb_err);
      end
      issue(5'd9);
      #1;
      checks++;
      if (iss_hazard !== 1'b0 || pending_cnt !== 6'd0) begin
         failures++; $display("FAIL waw_first got haz=%b pend=%0d, required 0 0", iss_hazard, pending_cnt);
      end
      issue(5'd9);
      #1;
      checks++;
      if (iss_hazard !== 1'b1) begin
         failures++; $display("FAIL waw_hazard got %b, required 1", iss_hazard);
      end
      @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (pending_cnt !== 6'd1 || wb_err !== 1'b1) begin
         failures++; $display("FAIL err_sticky got pend=%0d err=%b, required 1 1", pending_cnt, wb_err);
      end
      @(negedge clk);
      wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h0000_0099;
      expQ.push_back('{addr: 5'd9, data: 32'h0000_0099});
      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0 || pending_cnt !== 6'd0) begin
         failures++; $display("FAIL err_drain got queued=%0d pend=%0d, required 0 0", expQ.size(), pending_cnt);
      end
      do_reset();
      #1;
      checks++;
      if (wb_err !== 1'b0) begin
         failures++; $display("FAIL err_reset got %b, required 0", wb_err);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_raw();
      test_round_robin();
      test_back_to_back();
      test_x0();
      test_error_waw();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Writeback scheduler and scoreboard for the integer register file. It shares the register file's single write port between two writeback requesters, EXU (port 0) and LSU (port 1), using round-robin valid/ready arbitration. It drives the write port from a registered output stage. It also tracks in-flight destination registers so the decode stage can stall on RAW/WAW hazards. It sits between IDU/EXU/LSU and the register file's write port (write enable, write address, write data).

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  decode presents an instruction this cycle.
- iss_wen  in  1  instruction writes a destination register.
- iss_rd  in  ADDR_WIDTH  destination register of the issuing instruction.
- iss_rs1, iss_rs2  in  ADDR_WIDTH  source registers of the issuing instruction.
- iss_hazard  out  1  combinational; the issuing instruction must stall.
- wb0_valid, wb1_valid  in  1  writeback request from EXU / LSU.
- wb0_rd, wb1_rd  in  ADDR_WIDTH  writeback destination.
- wb0_data, wb1_data  in  DATA_WIDTH  writeback value.
- wb0_ready, wb1_ready  out  1  combinational grant.
- rf_wen  out  1  registered write enable to the register file.
- rf_waddr  out  ADDR_WIDTH  registered write address.
- rf_wdata  out  DATA_WIDTH  registered write data.
- pending_cnt  out  ADDR_WIDTH+1  number of busy registers.
- wb_err  out  1  sticky flag: a writeback targeted a non-busy nonzero register.

## Operation
- Scoreboard: busy[2**ADDR_WIDTH-1:0]. busy[0] is hardwired to 0.
- Hazard:
  - iss_hazard = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd])).
  - Register 0 never causes a hazard.
- Issue accept: iss_valid & !iss_hazard & iss_wen & (iss_rd != 0) sets busy[iss_rd] at the next edge.
- Arbitration:
  - State bit `last` records the last granted port; reset value 1, so port 0 wins the first conflict.
  - Only one port valid: that port is granted.
  - Both ports valid: the port != last is granted.
  - `last` updates only on a grant.
  - A port's ready is held low when it is not granted. The request must stay stable until accepted.
- Accept (valid & ready): the output stage loads at the next edge:
  - rf_wen = (rd != 0)
  - rf_waddr = rd
  - rf_wdata = data
- No grant: rf_wen = 0 next cycle. Address and data hold their previous values.
- The register file never backpressures, so the output stage never stalls.
- Busy clear: at the edge where rf_wen=1 is written into the file, busy[rf_waddr] clears. This is one edge after acceptance.
- Same-edge set and clear on different registers both take effect.
- Same-edge set and clear on the same register cannot legally occur, because the WAW hazard blocks it. If it does occur, set wins.
- wb_err: set on acceptance when rd != 0 and busy[rd] == 0. Cleared only by reset.
- pending_cnt: +1 on a set, -1 on a clear, unchanged on both or neither. Range 0 to 2**ADDR_WIDTH-1.

## Timing
- Reset (async assert, rst_n low) forces:
  - all busy bits = 0, pending_cnt = 0
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0
  - wb_err = 0, last = 1
- wb*_ready and iss_hazard are combinational and must not depend on any ready input.
- Latency: acceptance at edge N gives rf_wen high during cycle N to N+1. The file writes at edge N+1, and the busy bit clears at edge N+1.
- A dependent instruction sees iss_hazard = 0 from cycle N+1 onward, and reads the new value from the file combinationally.
- Throughput: one writeback per cycle. Under continuous dual requests, grants strictly alternate 0,1,0,1.
- Reset mid-operation drops the in-flight output stage and all scoreboard state. Requesters are reset alongside.

## Test plan
- Reset: hold rst_n=0 with all valids at 1 → rf_wen=0, pending_cnt=0, wb_err=0, both ready signals 0. Release reset → all outputs still at reset values.
- RAW stall:
  - Issue iss_rd=5 → pending_cnt=1.
  - Next issue with rs1=5 → iss_hazard=1.
  - wb0 rd=5 data=0xDEADBEEF accepted at edge N → rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1.
  - iss_hazard=0 and pending_cnt=0 after edge N+1.
- Round-robin: issue rd=3 and rd=4, then hold wb0 (rd=3) and wb1 (rd=4) valid together → wb0 granted first and wb1 the cycle after. rf_waddr sequence is 3 then 4.
- Continuous contention on 4 distinct busy registers (two per port) → grants alternate 0,1,0,1 with no idle cycle.
- x0 handling:
  - Issue rd=0 → pending_cnt stays 0.
  - wb1 rd=0 → accepted with ready=1, rf_wen stays 0, wb_err stays 0.
- Error and WAW:
  - wb0 rd=7 with busy[7]=0 → wb_err=1, persisting until reset.
  - Issue rd=9 twice without a writeback between → second issue sees iss_hazard=1.
